// File: rtl/mem_bus_ctrl.sv
// -----------------------------------------------------------------------------
// mem_bus_ctrl
//
// Bridges the pipeline memory stage to a simple request/acknowledge bus.
// The memory stage raises re or we and holds it while busy=1. The block
// latches the address, store data and direction, holds bus_req for the
// whole ACCESS phase and waits for bus_ack. Load data is captured into
// rdata on the ack edge. An access with no ack is aborted after TIMEOUT
// ACCESS cycles and flagged with a one-cycle err pulse.
//
// Parameters
//   TIMEOUT   : maximum ACCESS cycles before abort; 0 disables the timeout
//
// Ports
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   re, we    : read / write request (a write wins when both are set)
//   addr      : word address
//   wdata     : store data
//   rdata     : registered load data
//   busy      : pipeline stall request (combinational)
//   err       : access aborted by timeout (one DONE cycle)
//   bus_req   : bus transaction request, high exactly in ACCESS
//   bus_we    : 1 = write transaction
//   bus_addr  : latched word address
//   bus_wdata : latched store data
//   bus_ack   : transaction complete, bus_rdata valid in the same cycle
//   bus_rdata : read data from the bus
// -----------------------------------------------------------------------------
module mem_bus_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        re,
    input  logic        we,
    input  logic [29:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [29:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    // A zero TIMEOUT would give a zero-width counter; keep one bit so the
    // logic stays legal. The counter is unused in that case.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Abort when the count is about to reach TIMEOUT, so the last ACCESS
    // cycle is cycle number TIMEOUT.
    localparam logic [CW-1:0] T_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state_reg,     state_next;
    logic [CW-1:0] cnt_reg,       cnt_next;
    logic          bus_req_reg,   bus_req_next;
    logic          bus_we_reg,    bus_we_next;
    logic [29:0]   bus_addr_reg,  bus_addr_next;
    logic [31:0]   bus_wdata_reg, bus_wdata_next;
    logic [31:0]   rdata_reg,     rdata_next;
    logic          err_reg,       err_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            bus_req_reg   <= 1'b0;
            bus_we_reg    <= 1'b0;
            bus_addr_reg  <= '0;
            bus_wdata_reg <= '0;
            rdata_reg     <= '0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            bus_req_reg   <= bus_req_next;
            bus_we_reg    <= bus_we_next;
            bus_addr_reg  <= bus_addr_next;
            bus_wdata_reg <= bus_wdata_next;
            rdata_reg     <= rdata_next;
            err_reg       <= err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        bus_req_next   = 1'b0;
        bus_we_next    = bus_we_reg;
        bus_addr_next  = bus_addr_reg;
        bus_wdata_next = bus_wdata_reg;
        rdata_next     = rdata_reg;
        err_next       = 1'b0;
        busy           = 1'b0;

        case (state_reg)
            IDLE: begin
                // bus_ack is deliberately not looked at here.
                if (re || we) begin
                    busy           = 1'b1;
                    state_next     = ACCESS;
                    bus_req_next   = 1'b1;
                    cnt_next       = '0;
                    bus_we_next    = we;
                    bus_addr_next  = addr;
                    bus_wdata_next = wdata;
                end
            end
            ACCESS: begin
                busy = 1'b1;
                if (bus_ack) begin
                    // Ack beats a coinciding timeout.
                    state_next = DONE;
                    if (!bus_we_reg) begin
                        rdata_next = bus_rdata;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                    if ((TIMEOUT != 0) && (cnt_reg == T_LAST)) begin
                        state_next = DONE;
                        err_next   = 1'b1;
                    end else begin
                        bus_req_next = 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rdata     = rdata_reg;
    assign err       = err_reg;
    assign bus_req   = bus_req_reg;
    assign bus_we    = bus_we_reg;
    assign bus_addr  = bus_addr_reg;
    assign bus_wdata = bus_wdata_reg;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_ctrl
//
// Directed bench for mem_bus_ctrl (TIMEOUT=4). Stimulus pushes the expected
// completion of every access into a scoreboard queue; a monitor pops and
// compares whenever bus_req falls without reset (the DONE cycle).
// Cycle-level properties (busy, bus_req, latched fields, reset) are checked
// inline by the stimulus process.
// -----------------------------------------------------------------------------
module tb_mem_bus_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic [29:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic [31:0] rdata;
    logic        busy;
    logic        err;
    logic        bus_req;
    logic        bus_we;
    logic [29:0] bus_addr;
    logic [31:0] bus_wdata;

    mem_bus_ctrl #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .re        (re),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .busy      (busy),
        .err       (err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [29:0] addr;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic prev_req = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Start of the next cycle: just after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Sample point inside the current cycle.
    task automatic smp();
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rdata"},     rdata,     32'h0);
        check({tag, "_err"},       {31'h0, err},     32'h0);
        check({tag, "_bus_req"},   {31'h0, bus_req}, 32'h0);
        check({tag, "_bus_we"},    {31'h0, bus_we},  32'h0);
        check({tag, "_bus_addr"},  {2'b0, bus_addr}, 32'h0);
        check({tag, "_bus_wdata"}, bus_wdata, 32'h0);
    endtask

    // Scoreboard monitor: DONE is the cycle where bus_req has just fallen.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_req = 1'b0;
        end else begin
            if (prev_req && !bus_req) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected: completion at addr %h, expected none", bus_addr);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("done_rdata", rdata, mon_e.rdata);
                    check("done_err",   {31'h0, err}, {31'h0, mon_e.err});
                    check("done_addr",  {2'b0, bus_addr}, {2'b0, mon_e.addr});
                    check("done_busy",  {31'h0, busy}, 32'h0);
                    $display("[TB] txn addr=%h we=%b rdata=%h err=%b", bus_addr, bus_we, rdata, err);
                end
            end
            prev_req = bus_req;
        end
    end

    initial begin
        // ---------------- reset state ----------------
        #12;
        check_zero("rst");
        check("rst_busy", {31'h0, busy}, 32'h0);
        cyc();
        rst_n = 1'b1;

        // ---------------- read, zero wait ----------------
        cyc();
        re = 1'b1; addr = 30'h100;
        sb_q.push_back('{32'hDEADBEEF, 1'b0, 30'h100});
        smp();
        check("rd_c0_busy", {31'h0, busy}, 32'h1);
        check("rd_c0_req",  {31'h0, bus_req}, 32'h0);
        cyc();
        bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
        smp();
        check("rd_c1_req",  {31'h0, bus_req}, 32'h1);
        check("rd_c1_addr", {2'b0, bus_addr}, 32'h100);
        check("rd_c1_busy", {31'h0, busy}, 32'h1);
        check("rd_c1_we",   {31'h0, bus_we}, 32'h0);
        cyc();
        bus_ack = 1'b0; bus_rdata = '0; re = 1'b0;
        smp();
        check("rd_c2_rdata", rdata, 32'hDEADBEEF);
        check("rd_c2_busy",  {31'h0, busy}, 32'h0);
        cyc();
        smp();
        check("rd_c3_busy", {31'h0, busy}, 32'h0);
        check("rd_c3_req",  {31'h0, bus_req}, 32'h0);

        // ---------------- write, 3 wait states ----------------
        cyc();
        we = 1'b1; addr = 30'h200; wdata = 32'h12345678;
        sb_q.push_back('{32'hDEADBEEF, 1'b0, 30'h200});
        for (int c = 1; c <= 4; c++) begin
            cyc();
            if (c == 2) begin
                addr  = 30'h3FFFFFFF;
                wdata = 32'h0;
            end
            if (c == 4) bus_ack = 1'b1;
            smp();
            check("wr_req",   {31'h0, bus_req}, 32'h1);
            check("wr_we",    {31'h0, bus_we}, 32'h1);
            check("wr_wdata", bus_wdata, 32'h12345678);
            check("wr_addr",  {2'b0, bus_addr}, 32'h200);
        end
        cyc();
        bus_ack = 1'b0; we = 1'b0;
        smp();
        check("wr_c5_busy",  {31'h0, busy}, 32'h0);
        check("wr_c5_rdata", rdata, 32'hDEADBEEF);

        // ---------------- timeout, no ack ----------------
        cyc();
        re = 1'b1; addr = 30'h300;
        sb_q.push_back('{32'hDEADBEEF, 1'b1, 30'h300});
        for (int c = 1; c <= 4; c++) begin
            cyc();
            smp();
            check("to_req", {31'h0, bus_req}, 32'h1);
            check("to_err", {31'h0, err}, 32'h0);
        end
        cyc();
        re = 1'b0;
        smp();
        check("to_c5_err",   {31'h0, err}, 32'h1);
        check("to_c5_req",   {31'h0, bus_req}, 32'h0);
        check("to_c5_rdata", rdata, 32'hDEADBEEF);
        cyc();
        smp();
        check("to_c6_err", {31'h0, err}, 32'h0);

        // ---------------- ack coincides with timeout ----------------
        cyc();
        re = 1'b1; addr = 30'h400;
        sb_q.push_back('{32'hCAFEF00D, 1'b0, 30'h400});
        for (int c = 1; c <= 4; c++) begin
            cyc();
            if (c == 4) begin
                bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
            end
            smp();
            check("co_req", {31'h0, bus_req}, 32'h1);
        end
        cyc();
        bus_ack = 1'b0; re = 1'b0;
        smp();
        check("co_c5_err",   {31'h0, err}, 32'h0);
        check("co_c5_rdata", rdata, 32'hCAFEF00D);

        // ---------------- back-to-back, re=we=1, stray ack ----------------
        cyc();
        re = 1'b1; addr = 30'h500;
        sb_q.push_back('{32'h11112222, 1'b0, 30'h500});
        cyc();
        bus_ack = 1'b1; bus_rdata = 32'h11112222;
        smp();
        cyc();                                  // DONE, stray ack held
        re = 1'b1; we = 1'b1; addr = 30'h600; wdata = 32'hA5A5A5A5;
        bus_rdata = 32'hFFFFFFFF;
        sb_q.push_back('{32'h11112222, 1'b0, 30'h600});
        smp();
        check("bb_done_busy", {31'h0, busy}, 32'h0);
        cyc();                                  // IDLE, stray ack
        smp();
        check("bb_idle_busy",  {31'h0, busy}, 32'h1);
        check("bb_idle_req",   {31'h0, bus_req}, 32'h0);
        check("bb_idle_rdata", rdata, 32'h11112222);
        check("bb_idle_err",   {31'h0, err}, 32'h0);
        cyc();
        bus_ack = 1'b0;
        smp();
        check("bb_acc_req",   {31'h0, bus_req}, 32'h1);
        check("bb_acc_we",    {31'h0, bus_we}, 32'h1);
        check("bb_acc_addr",  {2'b0, bus_addr}, 32'h600);
        check("bb_acc_wdata", bus_wdata, 32'hA5A5A5A5);
        cyc();
        bus_ack = 1'b1; bus_rdata = 32'hFFFF0000;
        smp();
        cyc();
        bus_ack = 1'b0; re = 1'b0; we = 1'b0;
        smp();
        check("bb_wr_rdata", rdata, 32'h11112222);
        cyc();
        smp();
        check("bb_end_busy", {31'h0, busy}, 32'h0);

        // ---------------- reset mid-ACCESS ----------------
        cyc();
        re = 1'b1; addr = 30'h700;
        cyc();
        smp();
        cyc();
        check("mr_pre_req", {31'h0, bus_req}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("mr_async");
        re = 1'b0;
        cyc();
        rst_n = 1'b1;
        smp();
        check_zero("mr_rel");
        check("mr_rel_busy", {31'h0, busy}, 32'h0);
        #1;
        re = 1'b1; addr = 30'h800;
        sb_q.push_back('{32'h0BADCAFE, 1'b0, 30'h800});
        cyc();
        smp();
        check("mr_first_req",  {31'h0, bus_req}, 32'h1);
        check("mr_first_addr", {2'b0, bus_addr}, 32'h800);
        cyc();
        bus_ack = 1'b1; bus_rdata = 32'h0BADCAFE;
        cyc();
        bus_ack = 1'b0; re = 1'b0;
        smp();
        check("mr_rdata", rdata, 32'h0BADCAFE);
        cyc();
        smp();

        check("sb_empty", sb_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255: maximum ACCESS cycles before abort; 0 disables the timeout.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port re, input, 1 bit: read request from the memory stage; held while busy=1.
REQ-005 The block SHALL have port we, input, 1 bit: write request from the memory stage; held while busy=1.
REQ-006 The block SHALL have port addr, input, 30 bits: word address.
REQ-007 The block SHALL have port wdata, input, 32 bits: store data.
REQ-008 The block SHALL have port rdata, output, 32 bits: registered load data.
REQ-009 The block SHALL have port busy, output, 1 bit: pipeline stall request.
REQ-010 The block SHALL have port err, output, 1 bit: access aborted by timeout.
REQ-011 The block SHALL have port bus_req, output, 1 bit: bus transaction request.
REQ-012 The block SHALL have port bus_we, output, 1 bit: 1 = write transaction.
REQ-013 The block SHALL have port bus_addr, output, 30 bits: latched word address.
REQ-014 The block SHALL have port bus_wdata, output, 32 bits: latched store data.
REQ-015 The block SHALL have port bus_ack, input, 1 bit: transaction complete; bus_rdata valid in the same cycle.
REQ-016 The block SHALL have port bus_rdata, input, 32 bits: read data from the bus.

Function
REQ-017 The FSM SHALL have exactly three states, IDLE, ACCESS and DONE, and SHALL enter IDLE on reset.
REQ-018 In IDLE with re|we=1, the FSM SHALL latch addr, wdata and we into bus_addr, bus_wdata and bus_we, then move to ACCESS on the next edge.
REQ-019 When re and we are both 1, the block SHALL perform a write and ignore the read.
REQ-020 busy SHALL be combinational: 1 when (IDLE and (re|we)) or ACCESS; 0 in DONE and in idle IDLE.
REQ-021 bus_req SHALL be 1 exactly while in ACCESS, registered from the state.
REQ-022 bus_addr, bus_wdata and bus_we SHALL NOT change while bus_req=1.
REQ-023 In ACCESS with bus_ack=1, the FSM SHALL move to DONE.
- On a read, bus_rdata SHALL be captured into rdata on that same edge.
REQ-024 On a write, or on a timed-out access, rdata SHALL keep its previous value.
REQ-025 The timeout counter SHALL be $clog2(TIMEOUT+1) bits wide, cleared on entry to ACCESS, and incremented on each ACCESS cycle without bus_ack.
REQ-026 When TIMEOUT!=0 and the counter reaches TIMEOUT without ack, the FSM SHALL move to DONE with err=1.
- If bus_ack arrives in the same cycle, the ack SHALL win: normal completion, err=0.
REQ-027 err SHALL be registered, 1 only for the single DONE cycle of an aborted access, and 0 otherwise.
REQ-028 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
- A new request held in the following IDLE cycle SHALL start a new access, giving back-to-back operation.
REQ-029 bus_ack in IDLE or DONE SHALL be ignored and SHALL change no state or output.
REQ-030 Minimum latency: request seen in cycle 0, ack in cycle 1, DONE in cycle 2; busy=1 for exactly 2 cycles.

Reset
REQ-031 rst_n=0 SHALL immediately force the following, regardless of clk:
- state IDLE; counter 0;
- bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0;
- rdata=0, err=0.
REQ-032 Reset asserted mid-ACCESS SHALL drop bus_req in the same cycle and abandon the transaction; no rdata update.
REQ-033 After rst_n rises, the first request SHALL be accepted on the first clk edge.

Verification
REQ-034 Read with zero wait: re=1, addr=30'h100, ack in cycle 1 with bus_rdata=32'hDEADBEEF -> bus_addr=30'h100, bus_req high cycle 1 only, rdata=32'hDEADBEEF in cycle 2, busy high cycles 0-1.
REQ-035 Write with 3 wait states: we=1, wdata=32'h12345678, ack in cycle 4 -> bus_we=1 and bus_wdata stable cycles 1-4, rdata unchanged, busy low in cycle 5.
REQ-036 Timeout, TIMEOUT=4, no ack: re=1 -> ACCESS cycles 1-4, DONE in cycle 5 with err=1 and rdata unchanged; err=0 in cycle 6.
REQ-037 Ack and timeout coincide, TIMEOUT=4, ack in cycle 4 -> normal completion, err=0, rdata captured.
REQ-038 Back-to-back and simultaneous: read then write with re=we=1 on the second access -> the second access starts in the IDLE cycle after DONE with bus_we=1; a stray ack in IDLE has no effect.
REQ-039 Reset mid-ACCESS: rst_n pulled low in cycle 2 of a read -> bus_req=0 with no clock edge; after release, all outputs are 0 and the state is IDLE.
